// File: rtl/mips_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu_pkg
// Description : Shared ALU-control encodings: ALU operation codes, main-control
//               aluop classes, R-type funct values and the mult/div FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_alu_pkg;

    // ALU operation codes driven to the EX-stage ALU / mult-div unit
    localparam logic [3:0] ALU_SLL   = 4'b0000;
    localparam logic [3:0] ALU_SRL   = 4'b0001;
    localparam logic [3:0] ALU_SRA   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0011;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_AND   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1000;
    localparam logic [3:0] ALU_LUI   = 4'b1001;
    localparam logic [3:0] ALU_SUB   = 4'b1010;
    localparam logic [3:0] ALU_MULT  = 4'b1011;
    localparam logic [3:0] ALU_MULTU = 4'b1100;
    localparam logic [3:0] ALU_DIV   = 4'b1101;
    localparam logic [3:0] ALU_DIVU  = 4'b1110;
    localparam logic [3:0] ALU_NOP   = 4'b1111;

    // Main-control ALU classes
    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_XOR   = 3'b100;
    localparam logic [2:0] ALUOP_SLL   = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;
    localparam logic [2:0] ALUOP_LUI   = 3'b111;

    // R-type funct field values
    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_SRA   = 6'h03;
    localparam logic [5:0] FUNCT_SLLV  = 6'h04;
    localparam logic [5:0] FUNCT_SRLV  = 6'h06;
    localparam logic [5:0] FUNCT_SRAV  = 6'h07;
    localparam logic [5:0] FUNCT_JALR  = 6'h09;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;

    // Mult/div sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

endpackage : mips_alu_pkg
`default_nettype wire

// File: rtl/alu_funct_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_funct_decode
// Description : Combinational (aluop, funct) -> {alu code, is mult/div,
//               illegal} decode. Illegal inputs always yield ALU_NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_funct_decode
    import mips_alu_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int FUNCT_W = 6,
    parameter int CODE_W  = 4
) (
    input  logic [ALUOP_W-1:0] i_aluop,
    input  logic [FUNCT_W-1:0] i_funct,
    output logic [CODE_W-1:0]  o_code,
    output logic               o_is_md,
    output logic               o_illegal
);

    logic w_aluop_hi;

    // aluop encodings beyond the 3-bit class table are undefined
    generate
        if (ALUOP_W > 3) begin : g_aluop_wide
            assign w_aluop_hi = |i_aluop[ALUOP_W-1:3];
        end else begin : g_aluop_narrow
            assign w_aluop_hi = 1'b0;
        end
    endgenerate

    // Class decode first, then the R-type funct table
    always_comb begin
        o_code    = CODE_W'(ALU_NOP);
        o_is_md   = 1'b0;
        o_illegal = 1'b0;
        if (w_aluop_hi) begin
            o_illegal = 1'b1;
        end else begin
            case (i_aluop[2:0])
                ALUOP_ADD: o_code = CODE_W'(ALU_ADD);
                ALUOP_AND: o_code = CODE_W'(ALU_AND);
                ALUOP_OR:  o_code = CODE_W'(ALU_OR);
                ALUOP_XOR: o_code = CODE_W'(ALU_XOR);
                ALUOP_SLL: o_code = CODE_W'(ALU_SLL);
                ALUOP_SLT: o_code = CODE_W'(ALU_SLT);
                ALUOP_LUI: o_code = CODE_W'(ALU_LUI);
                default: begin
                    case (i_funct)
                        FUNCT_W'(FUNCT_SLL),  FUNCT_W'(FUNCT_SLLV): o_code = CODE_W'(ALU_SLL);
                        FUNCT_W'(FUNCT_SRL),  FUNCT_W'(FUNCT_SRLV): o_code = CODE_W'(ALU_SRL);
                        FUNCT_W'(FUNCT_SRA),  FUNCT_W'(FUNCT_SRAV): o_code = CODE_W'(ALU_SRA);
                        FUNCT_W'(FUNCT_ADDU), FUNCT_W'(FUNCT_JALR): o_code = CODE_W'(ALU_ADD);
                        FUNCT_W'(FUNCT_SUBU): o_code = CODE_W'(ALU_SUB);
                        FUNCT_W'(FUNCT_AND):  o_code = CODE_W'(ALU_AND);
                        FUNCT_W'(FUNCT_OR):   o_code = CODE_W'(ALU_OR);
                        FUNCT_W'(FUNCT_XOR):  o_code = CODE_W'(ALU_XOR);
                        FUNCT_W'(FUNCT_NOR):  o_code = CODE_W'(ALU_NOR);
                        FUNCT_W'(FUNCT_SLT):  o_code = CODE_W'(ALU_SLT);
                        FUNCT_W'(FUNCT_MULT): begin
                            o_code  = CODE_W'(ALU_MULT);
                            o_is_md = 1'b1;
                        end
                        FUNCT_W'(FUNCT_MULTU): begin
                            o_code  = CODE_W'(ALU_MULTU);
                            o_is_md = 1'b1;
                        end
                        FUNCT_W'(FUNCT_DIV): begin
                            o_code  = CODE_W'(ALU_DIV);
                            o_is_md = 1'b1;
                        end
                        FUNCT_W'(FUNCT_DIVU): begin
                            o_code  = CODE_W'(ALU_DIVU);
                            o_is_md = 1'b1;
                        end
                        default: o_illegal = 1'b1;
                    endcase
                end
            endcase
        end
    end

endmodule : alu_funct_decode
`default_nettype wire

// File: rtl/alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_seq
// Description : Registered ALU-control stage for the EX path. Decodes
//               aluop/funct with one cycle of latency and sequences
//               multi-cycle mult/div ops with a valid/ready stall.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_seq
    import mips_alu_pkg::*;
#(
    parameter int ALUOP_W    = 3,
    parameter int FUNCT_W    = 6,
    parameter int CODE_W     = 4,
    parameter int MD_LATENCY = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_flush,
    input  logic [ALUOP_W-1:0] i_aluop,
    input  logic [FUNCT_W-1:0] i_funct,
    output logic [CODE_W-1:0]  o_alu_code,
    output logic               o_valid,
    output logic               o_md_start,
    output logic               o_md_done,
    output logic               o_stall,
    output logic               o_illegal
);

    localparam int CNT_W = $clog2(MD_LATENCY + 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MD_LATENCY - 1);

    md_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CODE_W-1:0] r_alu_code, w_alu_code_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_md_start, w_md_start_nxt;
    logic              r_md_done, w_md_done_nxt;
    logic              r_illegal, w_illegal_nxt;

    logic [CODE_W-1:0] w_dec_code;
    logic              w_dec_is_md;
    logic              w_dec_illegal;
    logic              w_accept;

    alu_funct_decode #(
        .ALUOP_W (ALUOP_W),
        .FUNCT_W (FUNCT_W),
        .CODE_W  (CODE_W)
    ) u_decode (
        .i_aluop   (i_aluop),
        .i_funct   (i_funct),
        .o_code    (w_dec_code),
        .o_is_md   (w_dec_is_md),
        .o_illegal (w_dec_illegal)
    );

    assign o_ready    = (r_state == IDLE);
    assign o_stall    = (r_state != IDLE);
    assign w_accept   = i_valid & o_ready & ~i_flush;

    assign o_alu_code = r_alu_code;
    assign o_valid    = r_valid;
    assign o_md_start = r_md_start;
    assign o_md_done  = r_md_done;
    assign o_illegal  = r_illegal;

    // Next-state and next-output decode; pulses default low every cycle.
    // A single-cycle mult/div spends its one count cycle in BUSY so that
    // o_md_done always lands MD_LATENCY cycles after o_md_start.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_alu_code_nxt = r_alu_code;
        w_valid_nxt    = 1'b0;
        w_md_start_nxt = 1'b0;
        w_md_done_nxt  = 1'b0;
        w_illegal_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_alu_code_nxt = CODE_W'(ALU_NOP);
                if (w_accept) begin
                    if (w_dec_illegal) begin
                        w_illegal_nxt = 1'b1;
                    end else begin
                        w_alu_code_nxt = w_dec_code;
                        w_valid_nxt    = 1'b1;
                        if (w_dec_is_md) begin
                            w_md_start_nxt = 1'b1;
                            w_cnt_nxt      = c_cnt_load;
                            w_state_nxt    = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                if (i_flush) begin
                    w_state_nxt    = IDLE;
                    w_cnt_nxt      = '0;
                    w_alu_code_nxt = CODE_W'(ALU_NOP);
                end else if (r_cnt == '0) begin
                    w_state_nxt   = DONE;
                    w_md_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                if (i_flush) begin
                    w_cnt_nxt      = '0;
                    w_alu_code_nxt = CODE_W'(ALU_NOP);
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_cnt_nxt      = '0;
                w_alu_code_nxt = CODE_W'(ALU_NOP);
            end
        endcase
    end

    // State, counter and output registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_alu_code <= CODE_W'(ALU_NOP);
            r_valid    <= 1'b0;
            r_md_start <= 1'b0;
            r_md_done  <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_alu_code <= w_alu_code_nxt;
            r_valid    <= w_valid_nxt;
            r_md_start <= w_md_start_nxt;
            r_md_done  <= w_md_done_nxt;
            r_illegal  <= w_illegal_nxt;
        end
    end

endmodule : alu_control_seq
`default_nettype wire

// File: tb/tb_alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_seq
// Description : Directed self-checking bench for alu_control_seq, one
//               instance with MD_LATENCY=4 and one with MD_LATENCY=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_seq;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // MD_LATENCY = 4 instance
    logic       reset, i_valid, i_flush;
    logic [2:0] i_aluop;
    logic [5:0] i_funct;
    logic       o_ready, o_valid, o_md_start, o_md_done, o_stall, o_illegal;
    logic [3:0] o_alu_code;

    // MD_LATENCY = 1 instance
    logic       reset1, i_valid1, i_flush1;
    logic [2:0] i_aluop1;
    logic [5:0] i_funct1;
    logic       o_ready1, o_valid1, o_md_start1, o_md_done1, o_stall1, o_illegal1;
    logic [3:0] o_alu_code1;

    int n_checks = 0;
    int n_errors = 0;

    alu_control_seq #(.ALUOP_W(3), .FUNCT_W(6), .CODE_W(4), .MD_LATENCY(4)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .i_aluop(i_aluop), .i_funct(i_funct),
        .o_alu_code(o_alu_code), .o_valid(o_valid), .o_md_start(o_md_start),
        .o_md_done(o_md_done), .o_stall(o_stall), .o_illegal(o_illegal)
    );

    alu_control_seq #(.ALUOP_W(3), .FUNCT_W(6), .CODE_W(4), .MD_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset1), .i_valid(i_valid1), .o_ready(o_ready1),
        .i_flush(i_flush1), .i_aluop(i_aluop1), .i_funct(i_funct1),
        .o_alu_code(o_alu_code1), .o_valid(o_valid1), .o_md_start(o_md_start1),
        .o_md_done(o_md_done1), .o_stall(o_stall1), .o_illegal(o_illegal1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed single-cycle vectors: {aluop, funct, expected code}
    typedef struct {
        logic [2:0] aluop;
        logic [5:0] funct;
        logic [3:0] code;
    } vec_t;

    vec_t vecs [19] = '{
        '{3'd1, 6'h00, 4'h3}, '{3'd2, 6'h00, 4'h5}, '{3'd4, 6'h00, 4'h7},
        '{3'd5, 6'h00, 4'h0}, '{3'd6, 6'h00, 4'h4}, '{3'd7, 6'h00, 4'h9},
        '{3'd0, 6'h00, 4'h0}, '{3'd0, 6'h04, 4'h0}, '{3'd0, 6'h02, 4'h1},
        '{3'd0, 6'h06, 4'h1}, '{3'd0, 6'h03, 4'h2}, '{3'd0, 6'h07, 4'h2},
        '{3'd0, 6'h21, 4'h3}, '{3'd0, 6'h09, 4'h3}, '{3'd0, 6'h24, 4'h5},
        '{3'd0, 6'h25, 4'h6}, '{3'd0, 6'h26, 4'h7}, '{3'd0, 6'h27, 4'h8},
        '{3'd0, 6'h2A, 4'h4}
    };

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_aluop = 3'd0; i_funct = 6'h00;
        reset1 = 1'b1; i_valid1 = 1'b0; i_flush1 = 1'b0; i_aluop1 = 3'd0; i_funct1 = 6'h00;

        // Reset held two cycles
        tick(); tick();
        chk("rst_code",    32'(o_alu_code), 32'hF);
        chk("rst_ready",   32'(o_ready),    32'd1);
        chk("rst_stall",   32'(o_stall),    32'd0);
        chk("rst_valid",   32'(o_valid),    32'd0);
        chk("rst_start",   32'(o_md_start), 32'd0);
        chk("rst_done",    32'(o_md_done),  32'd0);
        chk("rst_illegal", 32'(o_illegal),  32'd0);
        reset = 1'b0; reset1 = 1'b0;
        tick();

        // subu then or, back to back
        i_valid = 1'b1; i_aluop = 3'd0; i_funct = 6'h23;
        tick();
        chk("subu_code",  32'(o_alu_code), 32'hA);
        chk("subu_valid", 32'(o_valid),    32'd1);
        chk("subu_stall", 32'(o_stall),    32'd0);
        i_aluop = 3'd3;
        tick();
        chk("or_code",  32'(o_alu_code), 32'h6);
        chk("or_valid", 32'(o_valid),    32'd1);
        chk("or_ready", 32'(o_ready),    32'd1);
        i_valid = 1'b0;
        tick();
        chk("bubble_valid", 32'(o_valid),    32'd0);
        chk("bubble_code",  32'(o_alu_code), 32'hF);

        // Single-cycle decode table, one op per cycle
        for (int i = 0; i < 19; i++) begin
            i_valid = 1'b1; i_aluop = vecs[i].aluop; i_funct = vecs[i].funct;
            tick();
            chk($sformatf("vec%0d_code", i), 32'(o_alu_code), 32'(vecs[i].code));
            chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'd1);
        end
        i_valid = 1'b0;
        tick();

        // div with MD_LATENCY=4; a new op offered while busy is ignored
        i_valid = 1'b1; i_aluop = 3'd0; i_funct = 6'h1A;
        tick();
        chk("div_start", 32'(o_md_start), 32'd1);
        chk("div_valid", 32'(o_valid),    32'd1);
        chk("div_code",  32'(o_alu_code), 32'hD);
        chk("div_stall", 32'(o_stall),    32'd1);
        chk("div_ready", 32'(o_ready),    32'd0);
        i_aluop = 3'd1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("div_stall_t%0d", k), 32'(o_stall),    32'd1);
            chk($sformatf("div_start_t%0d", k), 32'(o_md_start), 32'd0);
            chk($sformatf("div_valid_t%0d", k), 32'(o_valid),    32'd0);
            chk($sformatf("div_code_t%0d", k),  32'(o_alu_code), 32'hD);
            chk($sformatf("div_done_t%0d", k),  32'(o_md_done),  32'(k == 5));
        end
        i_valid = 1'b0;
        tick();
        chk("div_ready_t6", 32'(o_ready),   32'd1);
        chk("div_stall_t6", 32'(o_stall),   32'd0);
        chk("div_done_t6",  32'(o_md_done), 32'd0);
        tick();

        // mult flushed two cycles after accept
        i_valid = 1'b1; i_aluop = 3'd0; i_funct = 6'h18;
        tick();
        chk("mult_start", 32'(o_md_start), 32'd1);
        chk("mult_code",  32'(o_alu_code), 32'hB);
        i_valid = 1'b0;
        tick();
        chk("mult_stall_t2", 32'(o_stall), 32'd1);
        i_flush = 1'b1;
        tick();
        chk("flush_stall", 32'(o_stall),    32'd0);
        chk("flush_ready", 32'(o_ready),    32'd1);
        chk("flush_code",  32'(o_alu_code), 32'hF);
        i_flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("flush_nodone%0d", k), 32'(o_md_done), 32'd0);
        end

        // Flush and accept in the same IDLE cycle: flush wins
        i_valid = 1'b1; i_flush = 1'b1; i_aluop = 3'd1;
        tick();
        chk("fa_valid",   32'(o_valid),    32'd0);
        chk("fa_code",    32'(o_alu_code), 32'hF);
        i_flush = 1'b0; i_aluop = 3'd0; i_funct = 6'h3F;
        tick();
        chk("ill_pulse", 32'(o_illegal),  32'd1);
        chk("ill_valid", 32'(o_valid),    32'd0);
        chk("ill_code",  32'(o_alu_code), 32'hF);
        chk("ill_stall", 32'(o_stall),    32'd0);
        i_valid = 1'b0;
        tick();
        chk("ill_clear", 32'(o_illegal), 32'd0);

        // Illegal funct under flush is suppressed
        i_valid = 1'b1; i_flush = 1'b1;
        tick();
        chk("ill_flush", 32'(o_illegal), 32'd0);
        i_valid = 1'b0; i_flush = 1'b0;

        // MD_LATENCY=1: multu completes one cycle after start
        i_valid1 = 1'b1; i_aluop1 = 3'd0; i_funct1 = 6'h19;
        tick();
        chk("l1_start", 32'(o_md_start1), 32'd1);
        chk("l1_code",  32'(o_alu_code1), 32'hC);
        chk("l1_stall", 32'(o_stall1),    32'd1);
        chk("l1_done1", 32'(o_md_done1),  32'd0);
        i_valid1 = 1'b0;
        tick();
        chk("l1_done2",  32'(o_md_done1), 32'd1);
        chk("l1_stall2", 32'(o_stall1),   32'd1);
        tick();
        chk("l1_ready3", 32'(o_ready1),   32'd1);
        chk("l1_done3",  32'(o_md_done1), 32'd0);

        // MD_LATENCY=1: reset at T+1 kills the pending done
        i_valid1 = 1'b1;
        tick();
        chk("l1r_start", 32'(o_md_start1), 32'd1);
        i_valid1 = 1'b0; reset1 = 1'b1;
        tick();
        chk("l1r_done",  32'(o_md_done1),  32'd0);
        chk("l1r_ready", 32'(o_ready1),    32'd1);
        chk("l1r_code",  32'(o_alu_code1), 32'hF);
        reset1 = 1'b0;
        tick();
        chk("l1r_done2", 32'(o_md_done1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_control_seq
`default_nettype wire
